// File: rtl/clkbuf_div.sv
// clkbuf_div: per-channel clock divider emitting ce pulses and registered divided clocks; define CLKBUF_DIV_PENDING_EN for the pending output port.
module clkbuf_div #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*DIV_W-1:0] ratio,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       clkout
`ifdef CLKBUF_DIV_PENDING_EN
  ,
  output logic [NUM_CH-1:0]       pending
`endif
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIV_W-1:0] n, p, cnt, n_nx, p_nx, cnt_nx;
    logic pend, run, dis, wrap, bnd, pend_nx, run_nx, ce_q, clk_q;
    // bnd marks any point where a new period begins, so pending ratios apply there
    always_comb begin
      dis     = !en[c] || n == '0;
      wrap    = run && cnt == n - 1'b1;
      bnd     = dis || !run || sync || wrap;
      n_nx    = (pend && bnd) ? p : n;
      p_nx    = load[c] ? ratio[c*DIV_W +: DIV_W] : p;
      pend_nx = load[c] || (pend && !bnd);
      run_nx  = en[c] && n_nx != '0;
      cnt_nx  = bnd ? '0 : cnt + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        n     <= DIV_W'(DEF_RATIO);
        p     <= DIV_W'(DEF_RATIO);
        pend  <= 1'b0;
        run   <= 1'b0;
        cnt   <= '0;
        ce_q  <= 1'b0;
        clk_q <= 1'b0;
      end else begin
        n     <= n_nx;
        p     <= p_nx;
        pend  <= pend_nx;
        run   <= run_nx;
        cnt   <= cnt_nx;
        ce_q  <= run_nx && cnt_nx == n_nx - 1'b1;
        clk_q <= run_nx && {1'b0, cnt_nx} < (({1'b0, n_nx} + 1'b1) >> 1);
      end
    end
    assign ce[c]     = ce_q;
    assign clkout[c] = clk_q;
`ifdef CLKBUF_DIV_PENDING_EN
    assign pending[c] = pend;
`endif
  end
endmodule

// File: tb/tb_clkbuf_div.sv
// tb_clkbuf_div: directed and randomized checks of clkbuf_div against a cycle-level reference model.
module tb_clkbuf_div;
  localparam int NC = 2, DW = 8, DEF = 2;
  logic clk = 0, reset = 1, sync = 0;
  logic [NC-1:0] en = '0, load = '0, ce, clkout;
  logic [NC*DW-1:0] ratio = '0;
`ifdef CLKBUF_DIV_PENDING_EN
  logic [NC-1:0] pending;
`endif
  int mN[NC], mP[NC], mPh[NC];
  bit mPd[NC];
  int passed = 0, checks = 0, cyc = 0;

  clkbuf_div #(.NUM_CH(NC), .DIV_W(DW), .DEF_RATIO(DEF)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .ratio(ratio), .sync(sync),
    .ce(ce), .clkout(clkout)
`ifdef CLKBUF_DIV_PENDING_EN
    , .pending(pending)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // mPh is the position within the current period, -1 while the channel is idle
  task automatic model_step;
    for (int c = 0; c < NC; c++) begin
      bit off, bnd;
      if (reset) begin
        mN[c] = DEF; mP[c] = DEF; mPd[c] = 0; mPh[c] = -1;
      end else begin
        off = !en[c] || mN[c] == 0;
        bnd = off || mPh[c] < 0 || sync || mPh[c] == mN[c] - 1;
        if (bnd && mPd[c]) begin mN[c] = mP[c]; mPd[c] = 0; end
        mPh[c] = (!en[c] || mN[c] == 0) ? -1 : bnd ? 0 : mPh[c] + 1;
        if (load[c]) begin mP[c] = int'(ratio[c*DW +: DW]); mPd[c] = 1; end
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("ce%0d", c), 32'(ce[c]), 32'(mPh[c] >= 0 && mPh[c] == mN[c] - 1));
      chk($sformatf("clkout%0d", c), 32'(clkout[c]), 32'(mPh[c] >= 0 && mPh[c] < (mN[c] + 1) / 2));
`ifdef CLKBUF_DIV_PENDING_EN
      chk($sformatf("pending%0d", c), 32'(pending[c]), 32'(mPd[c]));
`endif
    end
    load = '0;
    sync = 0;
  endtask

  task automatic setr(input int c, input int v);
    ratio[c*DW +: DW] = DW'(v);
    load[c] = 1;
  endtask

  task automatic wait_for(input int c, input int n, input int ph);
    for (int k = 0; k < 40 && !(mN[c] == n && mPh[c] == ph && !mPd[c]); k++) tick();
  endtask

  initial begin
    repeat (3) tick();
    en = 2'b11;
    tick();
    chk("reset_ce", 32'(ce), 0);
    chk("reset_clk", 32'(clkout), 0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r031_clk", 32'(clkout), (i % 2 == 0) ? 3 : 0);
      chk("r031_ce", 32'(ce), (i % 2 == 1) ? 3 : 0);
    end
    setr(0, 4);
    tick();
    wait_for(0, 4, 1);
    setr(0, 6);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r032_clk", 32'(clkout[0]), (i >= 2 && i <= 4) ? 1 : 0);
      chk("r032_ce", 32'(ce[0]), (i == 1 || i == 7) ? 1 : 0);
    end
    setr(0, 5);
    tick();
    wait_for(0, 5, 4);
    setr(0, 7);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("r033_ce", 32'(ce[0]), (i == 4 || i == 11) ? 1 : 0);
`ifdef CLKBUF_DIV_PENDING_EN
      chk("r033_pend", 32'(pending[0]), (i < 5) ? 1 : 0);
`endif
    end
    setr(0, 3);
    setr(1, 5);
    tick();
    for (int k = 0; k < 20 && (mPd[0] || mPd[1]); k++) tick();
    tick();
    sync = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) chk("r034_clk", 32'(clkout), 3);
      chk("r034_ce0", 32'(ce[0]), (i == 2) ? 1 : 0);
      chk("r034_ce1", 32'(ce[1]), (i == 4) ? 1 : 0);
    end
    setr(1, 8);
    tick();
    wait_for(1, 8, 3);
    en[1] = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r035_off", {30'd0, ce[1], clkout[1]}, 0);
    end
    en[1] = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r035_clk", 32'(clkout[1]), (i < 4) ? 1 : 0);
    end
    setr(1, 0);
    repeat (10) tick();
    chk("r035_zero", {30'd0, ce[1], clkout[1]}, 0);
    setr(0, 6);
    tick();
    wait_for(0, 6, 2);
    reset = 1;
    repeat (2) tick();
    chk("r036_rst", {30'd0, ce[0], clkout[0]}, 0);
    reset = 0;
    tick();
    chk("r036_clk", 32'(clkout[0]), 1);
    tick();
    chk("r036_ce", 32'(ce[0]), 1);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NC; c++) begin
        en[c] = $urandom_range(0, 9) != 0;
        if ($urandom_range(0, 7) == 0) setr(c, $urandom_range(0, 9));
      end
      sync = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 199) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/clkbuf_div.md
CLKBUF_DIV -- requirements
Module: clkbuf_div

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent divided-clock channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8: width of each channel's divide ratio.
REQ-003 SHALL have parameter DEF_RATIO, default 2: ratio loaded into every channel at reset (1..2^DIV_W-1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, NUM_CH bits: per-channel run enable.
REQ-007 SHALL have port load, input, NUM_CH bits: per-channel single-cycle request to capture a new ratio.
REQ-008 SHALL have port ratio, input, NUM_CH*DIV_W bits: requested ratios; channel c uses bits [c*DIV_W +: DIV_W].
REQ-009 SHALL have port sync, input, 1 bit: phase-align request for all channels.
REQ-010 SHALL have port ce, output, NUM_CH bits: per-channel clock-enable pulse, one cycle wide.
REQ-011 SHALL have port clkout, output, NUM_CH bits: per-channel registered divided clock.

Function
REQ-012 Each channel SHALL hold an active ratio N, a pending ratio P, a pending flag, and a counter cnt counting 0..N-1.
REQ-013 With en[c]=1 and N>=1, cnt SHALL increment each cycle and wrap from N-1 to 0.
REQ-014 ce[c] SHALL be 1 exactly in the cycles where cnt==N-1, giving one pulse every N cycles; N=1 gives ce=1 every cycle.
REQ-015 clkout[c] SHALL come directly from a flop and SHALL equal 1 in the cycles where cnt < ceil(N/2), else 0; N=1 gives a constant 1.
REQ-016 A ratio value of 0 SHALL disable the channel: cnt is held at 0, ce=0, clkout=0.
REQ-017 load[c]=1 SHALL capture ratio[c] into P and set pending; a second load before it is applied SHALL overwrite P.
REQ-018 A pending ratio SHALL become active only at a period boundary: in the cycle where cnt wraps to 0, N<=P and pending clears. The new period starts with cnt=0.
REQ-019 If load and a wrap occur in the same cycle, the wrap SHALL use the old P (or keep N if nothing was pending), and the newly loaded value SHALL stay pending until the next wrap.
REQ-020 If the channel is disabled (en[c]=0 or N=0) while pending is set, P SHALL be applied immediately, with no boundary wait.
REQ-021 en[c]=0 SHALL force cnt=0 and ce[c]=clkout[c]=0 from the next cycle. When en returns to 1, the channel SHALL restart at cnt=0 on the next cycle.
REQ-022 sync=1 SHALL force cnt=0 in all enabled channels on the next cycle. Pending ratios SHALL be applied at the same time. This aligns all rising clkout edges.
REQ-023 sync SHALL take priority over a wrap in the same cycle. load in that cycle SHALL still capture and be applied at the next boundary.
REQ-024 Channels SHALL be independent, except for the shared sync input.
REQ-025 clkout[c] SHALL never produce a high or low phase shorter than one clk cycle, including across ratio changes, enable changes and sync.

Reset
REQ-026 While reset=1, every channel SHALL set N=DEF_RATIO, P=DEF_RATIO, pending=0 and cnt=0.
REQ-027 While reset=1, ce=0 and clkout=0 on all channels, and reset SHALL override en, load and sync.
REQ-028 If reset is asserted mid-period, the period SHALL be abandoned. The first cycle after reset deasserts SHALL have cnt=0, with ce and clkout following REQ-014 and REQ-015.

Configuration
REQ-029 Macro CLKBUF_DIV_PENDING_EN, when defined, SHALL add output port pending, NUM_CH bits, reflecting each channel's pending flag. It is 0 at reset and 1 from the cycle after load until the cycle after the ratio is applied.
REQ-030 Without CLKBUF_DIV_PENDING_EN, the pending port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Reset with DEF_RATIO=2, then en=2'b11 -> both ce pulse every 2nd cycle and clkout toggles 1,0,1,0 starting in the first cycle after reset.
REQ-032 Ch0 running at N=4, load ratio=6 at cnt=1 -> ce stays at a 4-cycle spacing until the wrap, then moves to a 6-cycle spacing. clkout goes 1,1,0,0 then 1,1,1,0,0,0, with no runt pulse.
REQ-033 Ch0 N=5, load=7 in the cycle where cnt=4 -> the next period is still 5 cycles, and 7 applies one period later; with the macro defined, pending is high across that span.
REQ-034 Ch0 N=3, ch1 N=5, sync pulse -> on the next cycle both cnt=0 and both clkout rise together; ch0 ce occurs 3 cycles later and ch1 ce 5 cycles later.
REQ-035 Ch1 N=8, drop en at cnt=3 for 4 cycles, then raise it -> ce and clkout are 0 while disabled, then the channel restarts at cnt=0 with clkout high for 4 cycles. load of ratio=0 then forces ce=0 and clkout=0.
REQ-036 Assert reset at cnt=2 of an N=6 period -> ce=0 and clkout=0 during reset. After reset, N=DEF_RATIO and pending=0.
